// File: rtl/irq_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
// Vector base and stride are per-instance parameters, so vec_addr takes them as arguments.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam int N_SRC_DEF = 4;
    localparam int ID_W      = $clog2(N_SRC_DEF);

    // Full 32-bit result; callers truncate to their address width (wraps modulo 2^ADDR_W).
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] id);
        return base + id * stride;
    endfunction

endpackage

// File: rtl/irq_vector_ctrl_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_vector_ctrl.sv
// N-source vectored interrupt controller with pending latches, masking and fixed priority.
// Define IRQ_NEST_EN to allow higher-priority sources to preempt one in service.
module irq_vector_ctrl
    import irq_pkg::*;
#(
    parameter int                N_SRC      = 4,
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 10'h3C0,
    parameter int                VEC_STRIDE = 4,
    parameter logic [N_SRC-1:0]  EDGE_MODE  = 4'b0011
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_SRC-1:0]           irq,
    input  logic                       global_en,
    input  logic                       we_mask,
    input  logic [N_SRC-1:0]           mask_in,
    input  logic                       s_use_interr,
    input  logic                       s_finished,
    output logic                       s_interruption,
    output logic [ADDR_W-1:0]          dir_from_exception,
    output logic [$clog2(N_SRC)-1:0]   active_id,
    output logic                       busy,
    output logic [N_SRC-1:0]           pending
);

    localparam int SRC_ID_W = $clog2(N_SRC);

    irq_state_e            state_reg, state_next;
    logic [N_SRC-1:0]      irq_q_reg;
    logic [N_SRC-1:0]      pending_reg, pending_next;
    logic [N_SRC-1:0]      mask_reg;
    logic [SRC_ID_W-1:0]   active_id_reg;
    logic [ADDR_W-1:0]     vec_reg;

    logic [N_SRC-1:0]      set_vec;
    logic [N_SRC-1:0]      clr_vec;
    logic [N_SRC-1:0]      eligible;
    logic                  win_valid;
    logic [SRC_ID_W-1:0]   win_id;

    logic                  take;
    logic                  load;
    logic [SRC_ID_W-1:0]   load_id;

    function automatic logic [ADDR_W-1:0] vec_of(input logic [SRC_ID_W-1:0] id);
        return ADDR_W'(vec_addr(32'(VEC_BASE), VEC_STRIDE, 32'(id)));
    endfunction

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign set_vec[gi] = EDGE_MODE[gi] ? (irq[gi] & ~irq_q_reg[gi]) : irq[gi];
        assign clr_vec[gi] = take && (active_id_reg == SRC_ID_W'(gi));
    end

    // A new request in the same cycle as its take keeps the latch set.
    assign pending_next = (pending_reg & ~clr_vec) | set_vec;
    assign eligible     = pending_reg & mask_reg & {N_SRC{global_en}};

    irq_prio_enc #(
        .N    (N_SRC),
        .ID_W (SRC_ID_W)
    ) u_prio_enc (
        .req   (eligible),
        .valid (win_valid),
        .id    (win_id)
    );

`ifdef IRQ_NEST_EN
    localparam int SP_W = $clog2(N_SRC + 1);

    logic [SRC_ID_W-1:0] stack_mem [N_SRC];
    logic [SP_W-1:0]     sp_reg;
    logic                push;
    logic                pop;
    logic [SRC_ID_W-1:0] stack_top;

    assign stack_top = stack_mem[SRC_ID_W'(sp_reg - 1'b1)];
`endif

    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        load       = 1'b0;
        load_id    = win_id;
`ifdef IRQ_NEST_EN
        push       = 1'b0;
        pop        = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    state_next = REQ;
                    load       = 1'b1;
                end
            end
            // Committed: id and vector frozen; s_finished is meaningless here.
            REQ: begin
                if (s_use_interr) begin
                    state_next = SERVICE;
                    take       = 1'b1;
                end
            end
            SERVICE: begin
`ifdef IRQ_NEST_EN
                if (s_finished) begin
                    if (sp_reg != '0) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        load_id = stack_top;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (win_valid && (win_id < active_id_reg)) begin
                    push       = 1'b1;
                    load       = 1'b1;
                    state_next = REQ;
                end
`else
                if (s_finished) begin
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            irq_q_reg     <= '0;
            pending_reg   <= '0;
            mask_reg      <= '1;
            active_id_reg <= '0;
            vec_reg       <= VEC_BASE;
        end else begin
            state_reg   <= state_next;
            irq_q_reg   <= irq;
            pending_reg <= pending_next;
            if (we_mask) begin
                mask_reg <= mask_in;
            end
            if (load) begin
                active_id_reg <= load_id;
                vec_reg       <= vec_of(load_id);
            end
        end
    end

`ifdef IRQ_NEST_EN
    // Preemption strictly raises priority, so depth never exceeds N_SRC-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_reg <= '0;
        end else if (push) begin
            sp_reg <= sp_reg + 1'b1;
        end else if (pop) begin
            sp_reg <= sp_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[SRC_ID_W'(sp_reg)] <= active_id_reg;
        end
    end
`endif

    assign s_interruption     = (state_reg == REQ);
    assign busy               = (state_reg != IDLE);
    assign dir_from_exception = vec_reg;
    assign active_id          = active_id_reg;
    assign pending            = pending_reg;

endmodule
